yadder_seq: RTL and testbench
=============================

// Module: yadder_seq
// PURPOSE
//   Multi-cycle, parametrised add/subtract unit. Processes a SIZE-bit operation CHUNK bits per
//   clock through a ripple chunk adder, with the carry held in a register between chunks.
//   Successor to the combinational ripple adder: adds subtract mode, cout/overflow/zero flags
//   and a start/done handshake. Sits beside the ALU datapath for area-constrained builds.
// PARAMETERS
//   SIZE   32  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  8   bits processed per cycle; CHUNK==SIZE is legal (single-chunk run)
//   N      SIZE/CHUNK (localparam)  chunk count = RUN-cycle count
// PORTS
//   clk    in   1     clock; all state updates on rising edge
//   rst    in   1     asynchronous, active-high reset
//   start  in   1     request; sampled only when ready==1
//   sub    in   1     0: z=a+b+cin; 1: z=a-b (a+~b+1, cin ignored)
//   a      in   SIZE  operand A; latched on accepted start
//   b      in   SIZE  operand B; latched on accepted start
//   cin    in   1     carry-in for add mode; latched on accepted start
//   ready  out  1     1 in IDLE and DONE (start accepted); 0 in RUN
//   done   out  1     one-cycle pulse: result registers are valid
//   z      out  SIZE  result register
//   cout   out  1     carry out of bit SIZE-1 (sub: 1 = no borrow)
//   ovf    out  1     signed overflow = carry into MSB XOR carry out of MSB
//   zero   out  1     1 when z==0 (registered together with z)
// BEHAVIOUR
//   Reset: state=IDLE; z, cout, ovf, zero, done = 0; ready = 1. Async: takes effect at once,
//     mid-RUN included; the partial op is discarded and no done is issued.
//   States: IDLE, RUN, DONE.
//   - IDLE:  start -> latch a, b^{SIZE{sub}}, carry=sub?1:cin; idx=0; go to RUN.
//   - RUN:   each edge adds chunk idx; stores the sum chunk in the accumulator and the carry
//            register; idx++. On idx==N-1 -> DONE, loading z/cout/ovf/zero from the final chunk.
//   - DONE:  done=1 for this cycle only. start -> RUN (back-to-back, new latch). Else -> IDLE.
//   - Latency: start accepted at edge 0; done high in the cycle after edge N (N=4 at defaults).
//     Throughput: one op per N+1 cycles.
//   - start while ready==0 is ignored (no queueing). a/b/cin/sub may change freely after
//     acceptance.
//   - z/cout/ovf/zero change only on the transition into DONE. They hold until the next op
//     completes. Partial sums are never visible on z.
//   - Arithmetic is modulo 2^SIZE. ovf uses the carry into the MSB from the last chunk's
//     internal ripple.
//   - Illegal SIZE%CHUNK!=0 is flagged by an elaboration-time $error.
// STRUCTURE
//   Shared package/include: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
//   Sub-module y_chunk_add #(CHUNK):
//     - combinational ripple of full-adder cells
//     - outputs sum, cout and c_msb (carry into the MSB)
//     - one instance only
//   Top level holds the FSM, idx counter ($clog2(N) bits, min 1), operand shift/accumulate
//   registers, carry register and flag registers.
// TESTING (SIZE=32, CHUNK=8 unless noted; check done exactly 5 cycles after the start edge)
//   1. add a=3, b=2, cin=1 -> z=6, cout=0, ovf=0, zero=0. Also the i,j in 0..3, cin in 0..1
//      sweep: z==i+j+cin.
//   2. add a=32'hFFFFFFFF, b=1, cin=0 -> z=0, cout=1, ovf=0, zero=1.
//      a=32'h7FFFFFFF, b=1 -> z=32'h80000000, ovf=1, cout=0.
//   3. sub a=5, b=7 -> z=32'hFFFFFFFE, cout=0, ovf=0. sub a=7, b=5 -> z=2, cout=1.
//      sub a=32'h80000000, b=1 -> z=32'h7FFFFFFF, ovf=1.
//   4. start pulsed during RUN with other operands -> ignored; first result unchanged.
//      start held through DONE -> second op accepted; its done arrives 5 cycles later.
//   5. rst asserted 2 cycles into RUN -> z=0, flags=0, ready=1 immediately; no done pulse.
//      A new op after release completes normally.
//   6. CHUNK=32 (N=1): a=10, b=20 -> z=30, done 2 cycles after the start edge.
//      Random 1000-op regression against a+b+cin / a-b reference.

Source files
------------

// File: rtl/yadder_seq_pkg.sv
// Shared definitions for the multi-cycle add/subtract unit: FSM encodings,
// flag bundle and the counter-width helper.
package yadder_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Chunk index width; a single-chunk build still gets a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/yadder_seq_if.sv
// Request/response bundle of yadder_seq: operands and start in, result, flags
// and ready/done handshake out.
interface yadder_seq_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic            sub;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
    logic            ready;
    logic            done;
    logic [SIZE-1:0] z;
    logic            cout;
    logic            ovf;
    logic            zero;

    modport master (
        output start, sub, a, b, cin,
        input  ready, done, z, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, done, z, cout, ovf, zero
    );

endinterface

// File: rtl/yadder_seq_chunk_add.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also
// exposes the carry into its MSB for signed-overflow detection.
module y_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar k = 0; k < CHUNK; k++) begin : g_fa
        assign o_sum[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
        assign w_c[k+1]   = (i_a[k] & i_b[k]) | (i_a[k] & w_c[k]) | (i_b[k] & w_c[k]);
    end

    assign o_cout  = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/yadder_seq.sv
// Multi-cycle SIZE-bit add/subtract: one CHUNK-bit slice per clock through a
// single ripple chunk adder, carry held in a register between slices.
module yadder_seq
    import yadder_seq_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    yadder_seq_if.slave  bus
);

    localparam int N     = SIZE / CHUNK;
    localparam int IDX_W = idx_width(N);

    if (SIZE % CHUNK != 0) begin : g_size_check
        $error("yadder_seq: SIZE (%0d) must be a multiple of CHUNK (%0d)", SIZE, CHUNK);
    end

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [SIZE-1:0]  r_a;
    logic [SIZE-1:0]  r_b;
    logic [SIZE-1:0]  r_acc;
    logic             r_carry;
    logic [SIZE-1:0]  r_z;
    flags_t           r_flags;

    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic [SIZE-1:0]  w_acc_next;
    logic             w_last;

    // Operands shift right each cycle so the active slice is always at bit 0.
    y_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .i_a     (r_a[CHUNK-1:0]),
        .i_b     (r_b[CHUNK-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // New slice enters at the top; after N cycles the full result is aligned.
    assign w_acc_next = SIZE'({w_sum, r_acc} >> CHUNK);
    assign w_last     = (r_idx == IDX_W'(N - 1));

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_z     <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + 1; the +1 rides in on the carry.
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {SIZE{bus.sub}};
                        r_carry <= bus.sub | bus.cin;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_z          <= w_acc_next;
                        r_flags.cout <= w_cout;
                        r_flags.ovf  <= w_c_msb ^ w_cout;
                        r_flags.zero <= (w_acc_next == '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready = (r_state != ST_RUN);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.z     = r_z;
    assign bus.cout  = r_flags.cout;
    assign bus.ovf   = r_flags.ovf;
    assign bus.zero  = r_flags.zero;

endmodule

// File: tb/tb_yadder_seq.sv
// Randomised self-checking bench for yadder_seq: a CHUNK=8 and a CHUNK=32
// instance compared against an integer-arithmetic reference model.
module tb_yadder_seq;

    localparam int SIZE = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    yadder_seq_if #(.SIZE(SIZE)) bus0 ();
    yadder_seq_if #(.SIZE(SIZE)) bus1 ();

    yadder_seq #(.SIZE(SIZE), .CHUNK(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    yadder_seq #(.SIZE(SIZE), .CHUNK(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        logic [31:0] z;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t   r;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sr;
        longint unsigned ur;
        if (sub) begin
            r.z    = a - b;
            r.cout = (a >= b);
            sr     = sa - sb;
        end else begin
            ur     = longint'(a) + longint'(b) + longint'(cin);
            r.z    = ur[31:0];
            r.cout = ur[32];
            sr     = sa + sb + longint'(cin);
        end
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.z == 32'd0);
        return r;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input logic ci);
        if (sel) begin
            bus1.start = st; bus1.sub = sb; bus1.a = a; bus1.b = b; bus1.cin = ci;
        end else begin
            bus0.start = st; bus0.sub = sb; bus0.a = a; bus0.b = b; bus0.cin = ci;
        end
    endtask

    task automatic scramble(input bit sel, input logic st);
        drive(sel, st, 1'($urandom), $urandom, $urandom, 1'($urandom));
    endtask

    function automatic logic get_done(input bit sel);
        return sel ? bus1.done : bus0.done;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? bus1.ready : bus0.ready;
    endfunction

    function automatic res_t get_res(input bit sel);
        res_t r;
        r.z    = sel ? bus1.z    : bus0.z;
        r.cout = sel ? bus1.cout : bus0.cout;
        r.ovf  = sel ? bus1.ovf  : bus0.ovf;
        r.zero = sel ? bus1.zero : bus0.zero;
        return r;
    endfunction

    task automatic check_res(input string tag, input bit sel, input res_t e);
        res_t r = get_res(sel);
        check({tag, "_z"},    64'(r.z),    64'(e.z));
        check({tag, "_cout"}, 64'(r.cout), 64'(e.cout));
        check({tag, "_ovf"},  64'(r.ovf),  64'(e.ovf));
        check({tag, "_zero"}, 64'(r.zero), 64'(e.zero));
    endtask

    // Waits for done after an accepted start edge; cycle k is the period after edge k-1.
    task automatic wait_done(input string tag, input bit sel, output int lat);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, "_busy"}, 64'(get_ready(sel)), 64'd0);
            if (get_done(sel)) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), sel ? 64'd2 : 64'd5);
    endtask

    task automatic run_op(input string tag, input bit sel, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input logic sub);
        int lat;
        @(negedge clk);
        drive(sel, 1'b1, sub, a, b, cin);
        @(posedge clk);
        #1 scramble(sel, 1'b0);
        wait_done(tag, sel, lat);
        if (lat > 0) check_res(tag, sel, model(a, b, cin, sub));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n_done;
        res_t e;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 64'(get_ready(s[0])), 64'd1);
            check("rst_done",  64'(get_done(s[0])),  64'd0);
            e = '{z: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
            check_res("rst", s[0], e);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases
        run_op("add_3_2_1", 1'b0, 32'd3, 32'd2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int c = 0; c < 2; c++)
                    run_op("sweep", 1'b0, 32'(i), 32'(j), c[0], 1'b0);
        run_op("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op("add_ovf",    1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op("sub_5_7",    1'b0, 32'd5, 32'd7, 1'b1, 1'b1);
        run_op("sub_7_5",    1'b0, 32'd7, 32'd5, 1'b0, 1'b1);
        run_op("sub_ovf",    1'b0, 32'h8000_0000, 32'd1, 1'b0, 1'b1);

        // Start pulsed mid-RUN must be ignored
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd23, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) drive(1'b0, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
            if (c == 3) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            if (get_done(1'b0)) begin
                lat = c;
                break;
            end
        end
        check("ign_lat", 64'(lat), 64'd5);
        check("ign_z", 64'(bus0.z), 64'd123);
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.done) n_done++;
        end
        check("ign_no_extra_done", 64'(n_done), 64'd0);

        // Start held through DONE: back-to-back acceptance
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd1000, 32'd1, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b1, 32'd50, 32'd8, 1'b0);
        wait_done("b2b_first", 1'b0, lat);
        check("b2b_first_z", 64'(bus0.z), 64'd1001);
        @(posedge clk);
        #1 scramble(1'b0, 1'b0);
        wait_done("b2b_second", 1'b0, lat);
        check("b2b_second_z", 64'(bus0.z), 64'd42);

        // Async reset two cycles into RUN
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'd77, 32'd88, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus0.ready), 64'd1);
        check("mid_rst_done",  64'(bus0.done),  64'd0);
        e = '{z: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        check_res("mid_rst", 1'b0, e);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.done) n_done++;
        end
        check("mid_rst_no_done", 64'(n_done), 64'd0);
        run_op("post_rst", 1'b0, 32'd1234, 32'd4321, 1'b1, 1'b0);

        // Single-chunk build
        run_op("n1_10_20", 1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
        run_op("n1_sub",   1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);

        // Random regression, corner operands mixed in
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] ra, rb;
            logic [31:0] corners [4];
            corners[0] = 32'h0000_0000;
            corners[1] = 32'hFFFF_FFFF;
            corners[2] = 32'h8000_0000;
            corners[3] = 32'h7FFF_FFFF;
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            run_op("rand", 1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
